// File: rtl/ps2_cmd_queue.sv
// ps2_cmd_queue: buffers one-hot PS/2 key commands in a small circular FIFO.
// A processor reads them through port-mapped IN_PORT. Status and flag
// readback are on a second port ID, and a three-state handshake FSM
// drives IRQ.
module ps2_cmd_queue #(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] CMD_PORT  = 8'h03,
    parameter logic [7:0] STAT_PORT = 8'h04
) (
    input  logic       Reloj,
    input  logic       RST,
    input  logic [7:0] CMD_IN,
    input  logic [7:0] PORT_ID,
    input  logic       READ_STROBE,
    input  logic       INT_ACK,
    output logic [7:0] IN_PORT,
    output logic       IRQ
);
    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, SERV} irq_state_e;

    logic [7:0]       cmd_q, cmd_d, cmd_prev_q, cmd_prev_d;
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0]       count_q, count_d;
    logic             ovf_q, ovf_d, err_q, err_d;
    logic             rd_cmd_prev_q, rd_stat_prev_q;
    logic             pop_dly_q;
    irq_state_e       state_q, state_d;
    logic             irq_q, irq_d;
    logic [7:0]       in_port_q, in_port_d;
    logic [7:0]       mem_q [DEPTH];

    logic       rd_cmd, rd_stat, pop_ev, clr_ev;
    logic       push_ev, code_ok, push_ok, pop_ok, ovf_ev, err_ev;
    logic       full, empty;
    logic [5:0] low6;

    // Event detection: key change, strobe rising edges, queue accept/drop.
    always_comb begin
        low6    = cmd_q[5:0];
        rd_cmd  = READ_STROBE && (PORT_ID == CMD_PORT);
        rd_stat = READ_STROBE && (PORT_ID == STAT_PORT);
        pop_ev  = rd_cmd && !rd_cmd_prev_q;
        clr_ev  = rd_stat && !rd_stat_prev_q;
        full    = (count_q == DEPTH_C);
        empty   = (count_q == 4'd0);
        push_ev = (cmd_q != cmd_prev_q) && (cmd_q != 8'h00);
        code_ok = (cmd_q[7:6] == 2'b00) && (low6 != 6'd0) &&
                  ((low6 & (low6 - 6'd1)) == 6'd0);
        pop_ok  = pop_ev && !empty;
        // A full queue still takes a push when a pop frees a slot the same cycle.
        push_ok = push_ev && code_ok && (!full || pop_ok);
        ovf_ev  = push_ev && code_ok && full && !pop_ok;
        err_ev  = push_ev && !code_ok;
    end

    // Next-state for command sampling, pointers, count, flags and read data.
    always_comb begin
        cmd_d      = CMD_IN;
        cmd_prev_d = cmd_q;
        wptr_d     = push_ok ? PTR_W'(wptr_q + 1'b1) : wptr_q;
        rptr_d     = pop_ok  ? PTR_W'(rptr_q + 1'b1) : rptr_q;
        count_d    = count_q;
        if (push_ok && !pop_ok)      count_d = count_q + 4'd1;
        else if (pop_ok && !push_ok) count_d = count_q - 4'd1;
        // A new event in the clearing cycle wins over the clear.
        ovf_d = (ovf_q && !clr_ev) || ovf_ev;
        err_d = (err_q && !clr_ev) || err_ev;
        // Read data reflects state before this cycle's pop or clear.
        in_port_d = 8'h00;
        if (PORT_ID == CMD_PORT)
            in_port_d = empty ? 8'h00 : mem_q[rptr_q];
        else if (PORT_ID == STAT_PORT)
            in_port_d = {ovf_q, err_q, 1'b0, full, empty, count_q[2:0]};
    end

    // IRQ handshake: SERV leaves on the registered pop so IRQ re-arms via IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (count_q != 4'd0) state_d = REQ;
            REQ:     if (INT_ACK) state_d = SERV;
            SERV:    if (pop_dly_q || count_q == 4'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        irq_d = (state_d == REQ);
    end

    // Control and datapath registers, all cleared asynchronously.
    always_ff @(posedge Reloj or negedge RST) begin
        if (!RST) begin
            cmd_q          <= 8'h00;
            cmd_prev_q     <= 8'h00;
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= 4'd0;
            ovf_q          <= 1'b0;
            err_q          <= 1'b0;
            rd_cmd_prev_q  <= 1'b0;
            rd_stat_prev_q <= 1'b0;
            pop_dly_q      <= 1'b0;
            state_q        <= IDLE;
            irq_q          <= 1'b0;
            in_port_q      <= 8'h00;
        end else begin
            cmd_q          <= cmd_d;
            cmd_prev_q     <= cmd_prev_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
            err_q          <= err_d;
            rd_cmd_prev_q  <= rd_cmd;
            rd_stat_prev_q <= rd_stat;
            pop_dly_q      <= pop_ev;
            state_q        <= state_d;
            irq_q          <= irq_d;
            in_port_q      <= in_port_d;
        end
    end

    // FIFO storage; contents are never observed while the queue is empty.
    always_ff @(posedge Reloj) begin
        if (push_ok) mem_q[wptr_q] <= cmd_q;
    end

    assign IN_PORT = in_port_q;
    assign IRQ     = irq_q;
endmodule

// File: tb/tb_ps2_cmd_queue.sv
// Self-checking bench for ps2_cmd_queue: scoreboard of expected entries
// pushed when keys are driven, popped when the processor reads CMD_PORT.
module tb_ps2_cmd_queue;
    logic       Reloj = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] CMD_IN = 8'h00;
    logic [7:0] PORT_ID = 8'h00;
    logic       READ_STROBE = 1'b0;
    logic       INT_ACK = 1'b0;
    logic [7:0] IN_PORT;
    logic       IRQ;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] sb[$];

    always #5 Reloj = ~Reloj;

    ps2_cmd_queue dut (
        .Reloj(Reloj), .RST(RST), .CMD_IN(CMD_IN), .PORT_ID(PORT_ID),
        .READ_STROBE(READ_STROBE), .INT_ACK(INT_ACK),
        .IN_PORT(IN_PORT), .IRQ(IRQ)
    );

    task automatic tick();
        @(posedge Reloj);
        #1;
    endtask

    function automatic logic [7:0] sb_next();
        if (sb.size() == 0) return 8'h00;
        return sb.pop_front();
    endfunction

    // One key press followed by release to 00, so repeated codes push again.
    task automatic send_key(input logic [7:0] code, input bit accept);
        if (accept) sb.push_back(code);
        CMD_IN = code; tick(); tick();
        CMD_IN = 8'h00; tick(); tick();
    endtask

    task automatic do_pop(output logic [7:0] v);
        PORT_ID = 8'h03; READ_STROBE = 1'b1; tick();
        v = IN_PORT;
        READ_STROBE = 1'b0; tick();
    endtask

    task automatic read_stat(output logic [7:0] v);
        PORT_ID = 8'h04; READ_STROBE = 1'b1; tick();
        v = IN_PORT;
        READ_STROBE = 1'b0; tick();
        PORT_ID = 8'h00;
    endtask

    task automatic ack_irq();
        INT_ACK = 1'b1; tick();
        INT_ACK = 1'b0; tick(); tick();
    endtask

    task automatic test_reset();
        logic [7:0] v;
        tick(); tick();
        n_checks++; if (IN_PORT !== 8'h00) begin n_fail++; $display("FAIL reset_in_port: got %h want 00", IN_PORT); end
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", IRQ); end
        RST = 1'b1; tick();
        read_stat(v);
        n_checks++; if (v !== 8'h08) begin n_fail++; $display("FAIL reset_status: got %h want 08", v); end
    endtask

    task automatic test_single();
        logic [7:0] v, e;
        sb.push_back(8'h20);
        CMD_IN = 8'h20; tick();
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL single_irq_k: got %b want 0", IRQ); end
        tick();
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL single_irq_k1: got %b want 0", IRQ); end
        tick();
        n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL single_irq_k2: got %b want 1", IRQ); end
        CMD_IN = 8'h00; tick();
        do_pop(v); e = sb_next();
        n_checks++; if (v !== e) begin n_fail++; $display("FAIL single_head: got %h want %h", v, e); end
        n_checks++; if (IN_PORT !== 8'h00) begin n_fail++; $display("FAIL single_after_pop: got %h want 00", IN_PORT); end
        read_stat(v);
        n_checks++; if (v !== 8'h08) begin n_fail++; $display("FAIL single_empty: got %h want 08", v); end
        ack_irq();
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL single_irq_clr: got %b want 0", IRQ); end
    endtask

    task automatic test_overflow();
        logic [7:0] v, e;
        logic [7:0] codes [5] = '{8'h20, 8'h10, 8'h20, 8'h10, 8'h20};
        for (int i = 0; i < 5; i++) send_key(codes[i], i < 4);
        n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL ovf_irq: got %b want 1", IRQ); end
        read_stat(v);
        n_checks++; if (v !== 8'h94) begin n_fail++; $display("FAIL ovf_stat1: got %h want 94", v); end
        read_stat(v);
        n_checks++; if (v !== 8'h14) begin n_fail++; $display("FAIL ovf_stat2: got %h want 14", v); end
        for (int i = 0; i < 4; i++) begin
            do_pop(v); e = sb_next();
            n_checks++; if (v !== e) begin n_fail++; $display("FAIL ovf_drain%0d: got %h want %h", i, v, e); end
        end
        read_stat(v);
        n_checks++; if (v !== 8'h08) begin n_fail++; $display("FAIL ovf_empty: got %h want 08", v); end
        ack_irq();
    endtask

    task automatic test_invalid();
        logic [7:0] v;
        CMD_IN = 8'h03; tick(); tick();
        CMD_IN = 8'h40; tick(); tick();
        CMD_IN = 8'h00; tick(); tick();
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL inv_irq: got %b want 0", IRQ); end
        read_stat(v);
        n_checks++; if (v !== 8'h48) begin n_fail++; $display("FAIL inv_stat1: got %h want 48", v); end
        read_stat(v);
        n_checks++; if (v !== 8'h08) begin n_fail++; $display("FAIL inv_stat2: got %h want 08", v); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] v, e;
        logic [7:0] codes [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
        for (int i = 0; i < 4; i++) send_key(codes[i], 1'b1);
        sb.push_back(8'h10);
        CMD_IN = 8'h10; PORT_ID = 8'h03; tick();
        READ_STROBE = 1'b1; tick();
        v = IN_PORT; e = sb_next();
        n_checks++; if (v !== e) begin n_fail++; $display("FAIL fpp_head: got %h want %h", v, e); end
        READ_STROBE = 1'b0; CMD_IN = 8'h00; tick();
        read_stat(v);
        n_checks++; if (v !== 8'h14) begin n_fail++; $display("FAIL fpp_stat: got %h want 14", v); end
        for (int i = 0; i < 4; i++) begin
            do_pop(v); e = sb_next();
            n_checks++; if (v !== e) begin n_fail++; $display("FAIL fpp_drain%0d: got %h want %h", i, v, e); end
        end
        ack_irq();
    endtask

    task automatic test_back_to_back();
        logic [7:0] v, e;
        send_key(8'h04, 1'b1);
        send_key(8'h08, 1'b1);
        // Held strobe: one pop only.
        PORT_ID = 8'h03; READ_STROBE = 1'b1; tick();
        e = sb_next();
        n_checks++; if (IN_PORT !== e) begin n_fail++; $display("FAIL hold_first: got %h want %h", IN_PORT, e); end
        tick();
        n_checks++; if (IN_PORT !== sb[0]) begin n_fail++; $display("FAIL hold_second: got %h want %h", IN_PORT, sb[0]); end
        tick();
        n_checks++; if (IN_PORT !== sb[0]) begin n_fail++; $display("FAIL hold_third: got %h want %h", IN_PORT, sb[0]); end
        READ_STROBE = 1'b0; tick();
        read_stat(v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL hold_stat: got %h want 01", v); end
        do_pop(v); e = sb_next();
        n_checks++; if (v !== e) begin n_fail++; $display("FAIL hold_last: got %h want %h", v, e); end
        // Push and pop together on an empty queue: push wins, pop ignored.
        sb.push_back(8'h02);
        CMD_IN = 8'h02; PORT_ID = 8'h03; tick();
        READ_STROBE = 1'b1; tick();
        n_checks++; if (IN_PORT !== 8'h00) begin n_fail++; $display("FAIL epp_head: got %h want 00", IN_PORT); end
        READ_STROBE = 1'b0; tick();
        n_checks++; if (IN_PORT !== sb[0]) begin n_fail++; $display("FAIL epp_kept: got %h want %h", IN_PORT, sb[0]); end
        CMD_IN = 8'h00;
        read_stat(v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL epp_stat: got %h want 01", v); end
        do_pop(v); e = sb_next();
        n_checks++; if (v !== e) begin n_fail++; $display("FAIL epp_pop: got %h want %h", v, e); end
        ack_irq();
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL b2b_irq: got %b want 0", IRQ); end
    endtask

    task automatic test_irq();
        logic [7:0] v, e;
        send_key(8'h20, 1'b1);
        send_key(8'h10, 1'b1);
        n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_raised: got %b want 1", IRQ); end
        INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_ack: got %b want 0", IRQ); end
        tick();
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_serv: got %b want 0", IRQ); end
        PORT_ID = 8'h03; READ_STROBE = 1'b1; tick();
        e = sb_next();
        n_checks++; if (IN_PORT !== e) begin n_fail++; $display("FAIL irq_pop1: got %h want %h", IN_PORT, e); end
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_m0: got %b want 0", IRQ); end
        READ_STROBE = 1'b0; tick();
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_m1: got %b want 0", IRQ); end
        tick();
        n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_m2: got %b want 1", IRQ); end
        INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_ack2: got %b want 0", IRQ); end
        do_pop(v); e = sb_next();
        n_checks++; if (v !== e) begin n_fail++; $display("FAIL irq_pop2: got %h want %h", v, e); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_final%0d: got %b want 0", i, IRQ); end
        end
        // Ack while idle must not disturb the next request.
        INT_ACK = 1'b1; tick(); INT_ACK = 1'b0; tick();
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_spurious: got %b want 0", IRQ); end
        send_key(8'h01, 1'b1);
        n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_after_spurious: got %b want 1", IRQ); end
        do_pop(v); e = sb_next();
        n_checks++; if (v !== e) begin n_fail++; $display("FAIL irq_pop3: got %h want %h", v, e); end
        ack_irq();
    endtask

    task automatic test_reset_mid();
        logic [7:0] v, e;
        send_key(8'h01, 1'b1);
        send_key(8'h02, 1'b1);
        send_key(8'h04, 1'b1);
        send_key(8'h03, 1'b0);
        PORT_ID = 8'h03; tick();
        n_checks++; if (IN_PORT !== sb[0]) begin n_fail++; $display("FAIL rst_pre_head: got %h want %h", IN_PORT, sb[0]); end
        #2 RST = 1'b0;
        #1;
        sb.delete();
        n_checks++; if (IN_PORT !== 8'h00) begin n_fail++; $display("FAIL rst_async_port: got %h want 00", IN_PORT); end
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL rst_async_irq: got %b want 0", IRQ); end
        tick(); tick();
        RST = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL rst_post_irq: got %b want 0", IRQ); end
        read_stat(v);
        n_checks++; if (v !== 8'h08) begin n_fail++; $display("FAIL rst_post_stat: got %h want 08", v); end
        do_pop(v); e = sb_next();
        n_checks++; if (v !== e) begin n_fail++; $display("FAIL rst_post_pop: got %h want %h", v, e); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_invalid();
        test_full_push_pop();
        test_back_to_back();
        test_irq();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_cmd_queue.md
PS2_CMD_QUEUE -- requirements
Module: ps2_cmd_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DEPTH, default 4, sets the queue entries; legal values are 2, 4 and 8.
REQ-003 Parameter CMD_PORT, default 8'h03, is the processor port ID that reads and pops commands.
REQ-004 Parameter STAT_PORT, default 8'h04, is the processor port ID that reads and clears status.
REQ-005 Reloj  in  1  system clock, 100 MHz.
REQ-006 RST  in  1  asynchronous reset, active-low (0 = reset).
REQ-007 CMD_IN  in  8  one-hot key command from the PS/2 translator.
- Bits, MSB to LSB: 0,0,UP,DO,RI,LE,TO,AS.
- 8'h00 means no command.
REQ-008 PORT_ID  in  8  processor port address.
REQ-009 READ_STROBE  in  1  processor read strobe.
REQ-010 INT_ACK  in  1  processor interrupt acknowledge, single-cycle pulse.
REQ-011 IN_PORT  out  8  registered read data to the processor.
REQ-012 IRQ  out  1  interrupt request to the processor.

Function
REQ-013 CMD_IN SHALL be registered into cmd_q every cycle, and the previous cmd_q SHALL be kept in cmd_prev.
REQ-014 A push event SHALL occur when cmd_q != cmd_prev and cmd_q != 8'h00.
- Because 8'h00 restarts detection, the same key pressed twice with a 00 between them gives two pushes.
REQ-015 A push event SHALL be valid only if cmd_q[7:6] = 0 and exactly one bit of cmd_q[5:0] is set.
- Invalid codes SHALL be dropped and SHALL set the sticky flag ERR.
REQ-016 A valid push SHALL write the entry at the edge after cmd_q updates.
- CMD_IN change sampled at edge k gives the entry, and EMPTY=0, at edge k+1.
REQ-017 The queue SHALL be a circular FIFO of DEPTH x 8 bits.
- The write and read pointers wrap modulo DEPTH.
- count ranges from 0 to DEPTH.
REQ-018 A pop event SHALL occur on the rising edge of (READ_STROBE && PORT_ID == CMD_PORT).
- A strobe held for several cycles gives exactly one pop.
REQ-019 A pop while the queue is empty SHALL have no effect.
REQ-020 A valid push while full and with no pop SHALL be dropped and SHALL set the sticky flag OVF.
REQ-021 Push and pop in the same cycle, queue non-empty: both SHALL occur and count SHALL be unchanged.
- This includes a full queue; the push is then accepted.
REQ-022 Push and pop in the same cycle, queue empty: the push SHALL be accepted and the pop ignored.
REQ-023 IN_PORT SHALL be updated every cycle from the current PORT_ID:
- CMD_PORT: the head entry, or 8'h00 if the queue is empty.
- STAT_PORT: {OVF, ERR, 1'b0, FULL, EMPTY, count[2:0]}.
- Any other port ID: 8'h00.
REQ-024 The head value SHALL be presented on IN_PORT before the pop that the same strobe triggers.
- The pointer advance becomes visible the cycle after the pop.
REQ-025 OVF and ERR SHALL clear on the rising edge of (READ_STROBE && PORT_ID == STAT_PORT).
- A new overflow or error in that same cycle SHALL leave its flag set.
REQ-026 The IRQ FSM SHALL have three states:
- IDLE, IRQ=0: go to REQ when count > 0.
- REQ, IRQ=1: go to SERV on INT_ACK.
- SERV, IRQ=0: go to IDLE on a pop event, or immediately if count = 0.
REQ-027 IRQ SHALL be a registered output decoded from the FSM state.
- It rises at edge k+2 for a first push sampled at edge k.
REQ-028 After a pop with entries remaining, the FSM SHALL pass through IDLE.
- IRQ therefore re-asserts exactly 2 cycles after that pop.
REQ-029 An INT_ACK received outside state REQ SHALL be ignored.

Reset
REQ-030 While RST=0, the block SHALL asynchronously clear the following:
- IN_PORT=8'h00 and IRQ=0.
- Pointers, count, OVF and ERR = 0.
- cmd_q and cmd_prev = 8'h00.
- FSM = IDLE.
REQ-031 A reset asserted mid-operation SHALL discard all queued entries.
- After release, the first push needs CMD_IN to differ from 8'h00.
REQ-032 FIFO storage contents need no reset, because they are unobservable while empty.

Verification
REQ-033 Single push/pop:
- Stimulus: CMD_IN 00->20, then PORT_ID=03 with a 1-cycle READ_STROBE.
- Response: IRQ=1 two cycles after sampling; IN_PORT=8'h20; then IN_PORT=8'h00 and EMPTY=1.
REQ-034 Overflow:
- Stimulus: 5 alternating valid codes (20,10,20,10,20) with 00 between each; then read STAT_PORT.
- Response: status = 8'b1001_0100 (OVF, FULL, count=4); a second status read gives 8'b0001_0100.
REQ-035 Invalid code:
- Stimulus: CMD_IN=8'h03, then CMD_IN=8'h40.
- Response: no push, ERR=1, count=0.
REQ-036 Simultaneous push and pop while full:
- Response: count stays 4, OVF stays 0, and the new entry is read last.
REQ-037 Interrupt handshake:
- Stimulus: 2 entries queued; INT_ACK; pop.
- Response: IRQ drops after the ack, re-asserts 2 cycles after the pop, and stays low after the final pop.
REQ-038 Reset:
- Stimulus: RST=0 with 3 entries queued.
- Response: IN_PORT=00, IRQ=0, EMPTY=1 immediately; after release, holding CMD_IN constant creates no push.
